mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: issues aligned, lane-enabled bus transfers for loads/stores and forms the stage result.
// Latency: 1 cycle for non-memory or misaligned ops; 1 + bus wait cycles for bus ops (aborted after TIMEOUT).
// Backpressure: single entry; in_ready only in IDLE, result held stable in HOLD until out_ready.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_branch,
    input  logic                  is_bne,
    input  logic                  alu_zero,
    input  logic [ADDR_W-1:0]     alu_out,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  load_unsigned,
    input  logic [DATA_W-1:0]     store_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_branch,
    output logic                  err_misalign,
    output logic                  err_timeout
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUS_WAIT, HOLD} state_t;

    state_t             state;
    state_t             stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic               busReq;
    logic               busWe;
    logic [ADDR_W-1:0]  busAddr;
    logic [LANES-1:0]   busBe;
    logic [DATA_W-1:0]  busWdata;
    logic [DATA_W-1:0]  outData;
    logic               outBranch;
    logic               errMisalign;
    logic               errTimeout;
    logic [OFF_W-1:0]   ldOff;
    logic [1:0]         ldSize;
    logic               ldUnsigned;
    logic               ldIsLoad;

    logic               accept;
    logic               isMem;
    logic               aligned;
    logic               waitExpired;
    logic [OFF_W-1:0]   addrOff;
    logic [LANES-1:0]   beBase;
    logic [LANES-1:0]   beCalc;
    logic [DATA_W-1:0]  wdataCalc;
    logic [DATA_W-1:0]  ldShifted;
    logic [DATA_W-1:0]  ldMask;
    logic               ldSign;
    logic [DATA_W-1:0]  ldValue;
    logic               inReady;
    logic               outValid;

    assign accept      = in_valid && inReady;
    assign isMem       = mem_read || mem_write;
    assign addrOff     = alu_out[OFF_W-1:0];
    assign waitExpired = (waitCnt == CNT_W'(TIMEOUT - 1));
    assign beCalc      = beBase << addrOff;
    assign wdataCalc   = store_data << {addrOff, 3'b000};
    assign ldShifted   = bus_rdata >> {ldOff, 3'b000};

    // Access legality and base lane mask from the requested size
    always_comb begin
        aligned = 1'b0;
        beBase  = '1;
        case (mem_size)
            2'b00: begin
                aligned = 1'b1;
                beBase  = LANES'(1);
            end
            2'b01: begin
                aligned = (alu_out[0] == 1'b0);
                beBase  = LANES'(3);
            end
            2'b10: begin
                aligned = (alu_out[1:0] == 2'b00);
                beBase  = LANES'(15);
            end
            default: begin
                aligned = (DATA_W == 64) && (alu_out[2:0] == 3'b000);
                beBase  = '1;
            end
        endcase
    end

    // Extract the addressed lanes of the read data and sign- or zero-extend them
    always_comb begin
        ldMask = '1;
        ldSign = ldShifted[DATA_W-1];
        case (ldSize)
            2'b00: begin
                ldMask = DATA_W'(8'hFF);
                ldSign = ldShifted[7];
            end
            2'b01: begin
                ldMask = DATA_W'(16'hFFFF);
                ldSign = ldShifted[15];
            end
            2'b10: begin
                ldMask = DATA_W'(32'hFFFF_FFFF);
                ldSign = ldShifted[31];
            end
            default: begin
                ldMask = '1;
                ldSign = ldShifted[DATA_W-1];
            end
        endcase
        ldValue = ldShifted & ldMask;
        if (!ldUnsigned && ldSign) begin
            ldValue = ldValue | ~ldMask;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and handshake outputs; ack beats the timeout when both land together
    always_comb begin
        stateNext = state;
        inReady   = 1'b0;
        outValid  = 1'b0;
        case (state)
            IDLE: begin
                inReady = reset;
                if (accept) begin
                    stateNext = (isMem && aligned) ? BUS_WAIT : HOLD;
                end
            end
            BUS_WAIT: begin
                if (bus_ack || waitExpired) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                outValid = 1'b1;
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Bus request, wait counter and result capture
    always_ff @(posedge clock) begin
        if (!reset) begin
            waitCnt     <= '0;
            busReq      <= 1'b0;
            busWe       <= 1'b0;
            busAddr     <= '0;
            busBe       <= '0;
            busWdata    <= '0;
            outData     <= '0;
            outBranch   <= 1'b0;
            errMisalign <= 1'b0;
            errTimeout  <= 1'b0;
            ldOff       <= '0;
            ldSize      <= 2'b00;
            ldUnsigned  <= 1'b0;
            ldIsLoad    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        outBranch   <= is_branch && (is_bne ^ alu_zero);
                        errMisalign <= isMem && !aligned;
                        errTimeout  <= 1'b0;
                        outData     <= DATA_W'(alu_out);
                        ldOff       <= addrOff;
                        ldSize      <= mem_size;
                        ldUnsigned  <= load_unsigned;
                        ldIsLoad    <= mem_read && !mem_write;
                        if (isMem && aligned) begin
                            busReq   <= 1'b1;
                            busWe    <= mem_write;
                            busAddr  <= alu_out & ~ADDR_W'(LANES - 1);
                            busBe    <= beCalc;
                            busWdata <= wdataCalc;
                            waitCnt  <= '0;
                        end
                    end
                end
                BUS_WAIT: begin
                    if (bus_ack) begin
                        busReq <= 1'b0;
                        if (ldIsLoad) begin
                            outData <= ldValue;
                        end
                    end else if (waitExpired) begin
                        busReq     <= 1'b0;
                        errTimeout <= 1'b1;
                        outData    <= '0;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = inReady;
    assign out_valid    = outValid;
    assign bus_req      = busReq;
    assign bus_we       = busWe;
    assign bus_addr     = busAddr;
    assign bus_be       = busBe;
    assign bus_wdata    = busWdata;
    assign out_data     = outData;
    assign out_branch   = outBranch;
    assign err_misalign = errMisalign;
    assign err_timeout  = errTimeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized transactions against a transaction-level model.
// Latency: model predicts per-edge windows for bus_req and out_valid from acceptance edge and ack delay.
// Backpressure: out_ready randomized with forced multi-cycle stalls; bus responder acks after a chosen delay.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        is_branch;
    logic        is_bne;
    logic        alu_zero;
    logic [31:0] alu_out;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic [31:0] store_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_branch;
    logic        err_misalign;
    logic        err_timeout;

    mem_access_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .is_branch(is_branch), .is_bne(is_bne), .alu_zero(alu_zero), .alu_out(alu_out),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .load_unsigned(load_unsigned), .store_data(store_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_branch(out_branch), .err_misalign(err_misalign), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int edgeN = 0;
    bit lastEdgeReset = 1'b1;

    always @(posedge clock) begin
        edgeN++;
        lastEdgeReset = !reset;
    end

    typedef struct {
        bit          valid;
        int          accEdge;
        int          popEdge;
        bit          isBus;
        int          busLen;
        int          ackDelay;
        logic [31:0] bAddr;
        logic [3:0]  bBe;
        logic        bWe;
        logic [31:0] wExp;
        logic [31:0] wMask;
        logic [31:0] rdata;
        logic [31:0] oData;
        logic        oBranch;
        logic        oMis;
        logic        oTo;
        int          stall;
    } txn_t;

    txn_t txn;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at edge %0d", nm, act, exp, edgeN);
        end
    endtask

    function automatic logic [31:0] loadValue(input logic [31:0] rd, input int off, input int nb,
                                              input logic uns);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < nb; k++) begin
            v = v | (64'(rd[8*(off+k) +: 8]) << (8*k));
        end
        if (!uns && v[8*nb-1]) begin
            v = v | ~((64'd1 << (8*nb)) - 64'd1);
        end
        return v[31:0];
    endfunction

    task automatic compareStep();
        int e;
        int vStart;
        bit expBus;
        bit expOv;
        bit expRdy;
        e = edgeN;
        expBus = 1'b0;
        expOv = 1'b0;
        if (lastEdgeReset) begin
            txn.valid = 1'b0;
            chk("rst_in_ready", in_ready, reset);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_bus_req", bus_req, 0);
            chk("rst_bus_we", bus_we, 0);
            chk("rst_bus_be", bus_be, 0);
            chk("rst_bus_addr", bus_addr, 0);
            chk("rst_bus_wdata", bus_wdata, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_branch", out_branch, 0);
            chk("rst_err_misalign", err_misalign, 0);
            chk("rst_err_timeout", err_timeout, 0);
        end else begin
            expBus = txn.valid && txn.isBus && e >= txn.accEdge && e < txn.accEdge + txn.busLen;
            vStart = txn.accEdge + (txn.isBus ? txn.busLen : 0);
            expOv  = txn.valid && e >= vStart && e < txn.popEdge;
            expRdy = !(txn.valid && e >= txn.accEdge && e < txn.popEdge);
            chk("in_ready", in_ready, expRdy);
            chk("bus_req", bus_req, expBus);
            chk("out_valid", out_valid, expOv);
            if (expBus) begin
                chk("bus_addr", bus_addr, txn.bAddr);
                chk("bus_be", bus_be, txn.bBe);
                chk("bus_we", bus_we, txn.bWe);
                chk("bus_wdata", bus_wdata & txn.wMask, txn.wExp);
            end
            if (expOv) begin
                chk("out_data", out_data, txn.oData);
                chk("out_branch", out_branch, txn.oBranch);
                chk("err_misalign", err_misalign, txn.oMis);
                chk("err_timeout", err_timeout, txn.oTo);
            end
        end
        if (expBus && (e - txn.accEdge) == txn.ackDelay) begin
            bus_ack   = 1'b1;
            bus_rdata = txn.rdata;
        end else begin
            bus_ack   = !expBus && ($urandom_range(0, 4) == 0);
            bus_rdata = $urandom;
        end
        if (expOv && txn.stall > 0) begin
            out_ready = 1'b0;
            txn.stall--;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end
        if (expOv && out_ready) begin
            txn.popEdge = e + 1;
        end
    endtask

    task automatic randomizeInputs();
        is_branch     = $urandom_range(0, 1);
        is_bne        = $urandom_range(0, 1);
        alu_zero      = $urandom_range(0, 1);
        alu_out       = $urandom;
        mem_read      = $urandom_range(0, 1);
        mem_write     = $urandom_range(0, 1);
        mem_size      = 2'($urandom_range(0, 3));
        load_unsigned = $urandom_range(0, 1);
        store_data    = $urandom;
    endtask

    // Called half a step after a falling edge; returns the same point one cycle after acceptance.
    task automatic send(input logic br, input logic bne, input logic az, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdat, input int ad, input int stall);
        txn_t t;
        int   nb;
        int   off;
        int   waited;
        bit   memOp;
        bit   aligned;
        waited = 0;
        while (!in_ready && waited < 60) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", in_ready, 1);
            return;
        end
        nb      = 1 << sz;
        off     = int'(addr % 4);
        memOp   = rd || wr;
        aligned = (sz != 2'd3) && ((addr % nb) == 0);
        t.valid    = 1'b1;
        t.accEdge  = edgeN + 1;
        t.popEdge  = 1 << 30;
        t.isBus    = memOp && aligned;
        t.ackDelay = ad;
        t.busLen   = (ad < TO) ? ad + 1 : TO;
        t.bAddr    = addr & ~32'd3;
        t.bWe      = wr;
        t.bBe      = '0;
        t.wExp     = '0;
        t.wMask    = '0;
        if (t.isBus) begin
            for (int k = 0; k < nb; k++) begin
                t.bBe[off+k]           = 1'b1;
                t.wExp[8*(off+k) +: 8]  = sd[8*k +: 8];
                t.wMask[8*(off+k) +: 8] = 8'hFF;
            end
        end
        t.rdata   = rdat;
        t.oBranch = br && (bne ^ az);
        t.oMis    = memOp && !aligned;
        t.oTo     = t.isBus && (ad >= TO);
        if (t.oTo) begin
            t.oData = 32'd0;
        end else if (t.isBus && !wr) begin
            t.oData = loadValue(rdat, off, nb, uns);
        end else begin
            t.oData = addr;
        end
        t.stall = stall;
        txn = t;
        is_branch = br; is_bne = bne; alu_zero = az; alu_out = addr;
        mem_read = rd; mem_write = wr; mem_size = sz; load_unsigned = uns; store_data = sd;
        in_valid = 1'b1;
        @(negedge clock);
        #1;
        in_valid = 1'b0;
        randomizeInputs();
    endtask

    initial begin
        int n;
        logic [7:0] topLane;
        reset = 1'b0;
        in_valid = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = '0;
        out_ready = 1'b0;
        txn = '{default: 0};
        randomizeInputs();
        fork
            begin
                repeat (3) @(negedge clock);
                #1;
                reset = 1'b1;
                @(negedge clock);
                #1;

                // Taken bne branch, no memory op
                send(1, 1, 0, 0, 0, 2'd2, 0, 32'h0000_4444, 32'h0, 32'h0, 0, 0);
                chk("dir_branch_valid", out_valid, 1);
                chk("dir_branch_taken", out_branch, 1);

                // Byte store to the top lane
                send(0, 0, 0, 0, 1, 2'd0, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1, 0);
                topLane = bus_wdata[31:24];
                chk("dir_sb_req", bus_req, 1);
                chk("dir_sb_addr", bus_addr, 32'h0000_1000);
                chk("dir_sb_be", bus_be, 4'b1000);
                chk("dir_sb_lane", topLane, 8'hAB);
                chk("dir_sb_we", bus_we, 1);

                // Signed half load, ack on the final allowed wait cycle, downstream stalls 5 cycles
                send(0, 0, 0, 1, 0, 2'd1, 0, 32'h0000_2002, 32'h0, 32'h80FF_1234, 3, 5);
                n = 0;
                while (!out_valid && n < 40) begin
                    @(negedge clock);
                    #1;
                    n++;
                end
                chk("dir_lh_valid", out_valid, 1);
                chk("dir_lh_data", out_data, 32'hFFFF_80FF);
                chk("dir_lh_errs", {err_misalign, err_timeout}, 2'b00);
                repeat (3) begin
                    @(negedge clock);
                    #1;
                end
                chk("dir_stall_hold", out_valid, 1);
                chk("dir_stall_data", out_data, 32'hFFFF_80FF);

                // Misaligned word load
                send(0, 0, 0, 1, 0, 2'd2, 0, 32'h0000_3001, 32'h0, 32'h0, 0, 0);
                chk("dir_mis_valid", out_valid, 1);
                chk("dir_mis_flag", err_misalign, 1);
                chk("dir_mis_noreq", bus_req, 0);

                // Bus never acks: abort after TIMEOUT request cycles
                send(0, 0, 1, 1, 0, 2'd2, 1, 32'h0000_5000, 32'h0, 32'h0, 9, 0);
                n = 0;
                while (bus_req && n < 20) begin
                    @(negedge clock);
                    #1;
                    n++;
                end
                chk("dir_to_len", n, 4);
                chk("dir_to_valid", out_valid, 1);
                chk("dir_to_flag", err_timeout, 1);
                chk("dir_to_data", out_data, 32'h0);

                // Reset while waiting on the bus
                send(0, 0, 0, 1, 0, 2'd2, 0, 32'h0000_6000, 32'h0, 32'h1, 50, 0);
                chk("dir_rst_req_before", bus_req, 1);
                reset = 1'b0;
                @(negedge clock);
                #1;
                chk("dir_rst_req_drop", bus_req, 0);
                chk("dir_rst_in_ready_low", in_ready, 0);
                @(negedge clock);
                #1;
                reset = 1'b1;
                @(negedge clock);
                #1;
                chk("dir_rst_in_ready_high", in_ready, 1);
                chk("dir_rst_no_valid", out_valid, 0);

                // Randomized traffic
                for (int i = 0; i < 300; i++) begin
                    int m;
                    logic [31:0] a;
                    repeat ($urandom_range(0, 2)) begin
                        @(negedge clock);
                        #1;
                    end
                    m = $urandom_range(0, 4);
                    a = $urandom;
                    if ($urandom_range(0, 2) != 0) a = a & ~32'h7;
                    send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         (m == 1) || (m == 3), (m >= 2) && (m != 4), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), a, $urandom, $urandom,
                         $urandom_range(0, 5), ($urandom_range(0, 7) == 0) ? 5 : 0);
                end

                n = 0;
                while (!in_ready && n < 60) begin
                    @(negedge clock);
                    #1;
                    n++;
                end
                chk("drain_in_ready", in_ready, 1);
                repeat (2) @(negedge clock);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clock);
                    compareStep();
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
